// File: rtl/iter_multdiv.sv
`default_nettype none
// ============================================================================
// Module   : iter_multdiv
// Purpose  : Iterative signed 32-bit multiply (radix-4 Booth, 16 steps) and
//            divide (restoring on magnitudes, 32 steps + sign fix-up).
//            Optional MULTIDIV_EARLY_OUT_EN: zero operands finish in one cycle.
// Revision : 1.0 - initial release
// ============================================================================
module iter_multdiv (
    input  logic        clock,
    input  logic        reset,
    input  logic        ctrl_MULT,
    input  logic        ctrl_DIV,
    input  logic [31:0] data_operandA,
    input  logic [31:0] data_operandB,
    output logic [31:0] data_result,
    output logic        data_exception,
    output logic        data_resultRDY,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_nextState;
    logic [4:0]  r_count;
    logic        r_fix;
    logic [63:0] r_acc;
    logic [63:0] r_mcand;
    logic [32:0] r_mplier;
    logic [31:0] r_rem;
    logic [31:0] r_quo;
    logic [31:0] r_divisor;
    logic        r_negQuo;
    logic        r_divZero;
    logic        r_divOvf;

    logic        w_start;
    logic        w_earlyOut;
    logic [63:0] w_pp;
    logic [32:0] w_shifted;
    logic        w_fits;
    logic [31:0] w_remSub;
    logic        w_mulOvf;

    assign w_start = ((r_state == IDLE) || (r_state == DONE)) && (ctrl_MULT || ctrl_DIV);

`ifdef MULTIDIV_EARLY_OUT_EN
    assign w_earlyOut = ctrl_MULT ? ((data_operandA == 32'd0) || (data_operandB == 32'd0))
                                  : (data_operandB == 32'd0);
`else
    assign w_earlyOut = 1'b0;
`endif

    // Booth digit from multiplier bits (2i+1, 2i, 2i-1)
    always_comb begin
        w_pp = 64'd0;
        case (r_mplier[2:0])
            3'b001, 3'b010: w_pp = r_mcand;
            3'b011:         w_pp = r_mcand << 1;
            3'b100:         w_pp = -(r_mcand << 1);
            3'b101, 3'b110: w_pp = -r_mcand;
            default:        w_pp = 64'd0;
        endcase
    end

    assign w_shifted = {r_rem, r_quo[31]};
    assign w_fits    = (w_shifted >= {1'b0, r_divisor});
    assign w_remSub  = w_shifted[31:0] - r_divisor;
    assign w_mulOvf  = ~((&r_acc[63:31]) | ~(|r_acc[63:31]));

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE, DONE: if (w_start) w_nextState = ctrl_MULT ? MUL : DIV;
            MUL, DIV:   if (r_fix) w_nextState = DONE;
            default:    w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_nextState;
    end

    assign busy = (r_state == MUL) || (r_state == DIV);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_count        <= 5'd0;
            r_fix          <= 1'b0;
            r_acc          <= 64'd0;
            r_mcand        <= 64'd0;
            r_mplier       <= 33'd0;
            r_rem          <= 32'd0;
            r_quo          <= 32'd0;
            r_divisor      <= 32'd0;
            r_negQuo       <= 1'b0;
            r_divZero      <= 1'b0;
            r_divOvf       <= 1'b0;
            data_result    <= 32'd0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
        end else begin
            data_resultRDY <= 1'b0;
            if (w_start) begin
                r_count   <= 5'd0;
                r_fix     <= w_earlyOut;
                r_acc     <= 64'd0;
                r_mcand   <= {{32{data_operandA[31]}}, data_operandA};
                r_mplier  <= {data_operandB, 1'b0};
                r_rem     <= 32'd0;
                r_quo     <= data_operandA[31] ? -data_operandA : data_operandA;
                r_divisor <= data_operandB[31] ? -data_operandB : data_operandB;
                r_negQuo  <= data_operandA[31] ^ data_operandB[31];
                r_divZero <= (data_operandB == 32'd0);
                r_divOvf  <= (data_operandA == 32'h8000_0000) && (data_operandB == 32'hFFFF_FFFF);
            end else if (r_state == MUL) begin
                if (r_fix) begin
                    r_fix          <= 1'b0;
                    data_result    <= r_acc[31:0];
                    data_exception <= w_mulOvf;
                    data_resultRDY <= 1'b1;
                end else begin
                    r_acc    <= r_acc + w_pp;
                    r_mcand  <= r_mcand << 2;
                    r_mplier <= {{2{r_mplier[32]}}, r_mplier[32:2]};
                    r_count  <= r_count + 5'd1;
                    if (r_count == 5'd15) r_fix <= 1'b1;
                end
            end else if (r_state == DIV) begin
                if (r_fix) begin
                    r_fix          <= 1'b0;
                    data_resultRDY <= 1'b1;
                    // Magnitude quotient of MIN/-1 is already 0x80000000 with no negation
                    if (r_divZero) begin
                        data_result    <= 32'd0;
                        data_exception <= 1'b1;
                    end else begin
                        data_result    <= r_negQuo ? -r_quo : r_quo;
                        data_exception <= r_divOvf;
                    end
                end else begin
                    r_rem   <= w_fits ? w_remSub : w_shifted[31:0];
                    r_quo   <= {r_quo[30:0], w_fits};
                    r_count <= r_count + 5'd1;
                    if (r_count == 5'd31) r_fix <= 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire
